// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus transmitter.
package cdb_pkg;

    localparam int CDB_TAG_W     = 4;
    localparam int CDB_ROB_PTR_W = 4;
    localparam int CDB_DATA_W    = 32;

    // Tag value meaning "no producer"; it must never appear on the bus.
    localparam int CDB_NULL_TAG  = 0;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]     tag;
        logic [CDB_ROB_PTR_W-1:0] inst_id;
        logic [CDB_DATA_W-1:0]    wdata;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO with wrap-bit pointers; flush and reset empty it.
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int  Q_DEPTH = 2,
    parameter type pkt_t   = cdb_pkt_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  pkt_t wr_pkt,
    output logic full,
    output logic empty,
    output pkt_t head
);

    localparam int PTR_W = $clog2(Q_DEPTH);

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    pkt_t           mem [Q_DEPTH];

    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= wr_pkt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full)) else $error("cdb_src_fifo: push into full FIFO");
        end
    end
`endif

endmodule

// File: rtl/cdb_arb.sv
// CDB transmitter: per-source FIFOs, round-robin pick of one head per cycle, registered broadcast.
module cdb_arb
    import cdb_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int TAG_W     = 4,
    parameter int ROB_DEPTH = 16,
    parameter int ROB_PTR_W = $clog2(ROB_DEPTH),
    parameter int DATA_W    = 32,
    parameter int Q_DEPTH   = 2,
    parameter int SRC_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [N_SRC-1:0]           src_req,
    output logic [N_SRC-1:0]           src_rdy,
    input  logic [N_SRC*TAG_W-1:0]     src_tag,
    input  logic [N_SRC*ROB_PTR_W-1:0] src_inst_id,
    input  logic [N_SRC*DATA_W-1:0]    src_wdata,
    output logic                       cdb_wr,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [ROB_PTR_W-1:0]       cdb_inst_id,
    output logic [DATA_W-1:0]          cdb_wdata
);

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [ROB_PTR_W-1:0] inst_id;
        logic [DATA_W-1:0]    wdata;
    } pkt_t;

    pkt_t             in_pkt [N_SRC];
    pkt_t             head   [N_SRC];
    logic [N_SRC-1:0] full;
    logic [N_SRC-1:0] empty;
    logic [N_SRC-1:0] push;
    logic [N_SRC-1:0] pop;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] winner;
    logic [SRC_W-1:0] rr_next;
    logic             found;
    pkt_t             win_pkt;

    // Ready is purely the FIFO's full flag, so req never feeds rdy combinationally.
    assign src_rdy = ~full;

    for (genvar s = 0; s < N_SRC; s++) begin : g_src
        assign in_pkt[s] = {src_tag[s*TAG_W +: TAG_W],
                            src_inst_id[s*ROB_PTR_W +: ROB_PTR_W],
                            src_wdata[s*DATA_W +: DATA_W]};
        assign push[s]   = src_req[s] & ~full[s];
        assign pop[s]    = found && (winner == SRC_W'(s));

        cdb_src_fifo #(
            .Q_DEPTH (Q_DEPTH),
            .pkt_t   (pkt_t)
        ) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .flush  (flush),
            .push   (push[s]),
            .pop    (pop[s]),
            .wr_pkt (in_pkt[s]),
            .full   (full[s]),
            .empty  (empty[s]),
            .head   (head[s])
        );
    end

    // Round-robin search from rr_ptr, wrapping explicitly at N_SRC.
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] cand;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            cand = SRC_W'(idx);
            if (!found && !empty[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign win_pkt = head[winner];
    assign rr_next = (winner == SRC_W'(N_SRC - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rr_ptr      <= '0;
            cdb_wr      <= 1'b0;
            cdb_tag     <= '0;
            cdb_inst_id <= '0;
            cdb_wdata   <= '0;
        end else if (found) begin
            rr_ptr      <= rr_next;
            cdb_wr      <= 1'b1;
            cdb_tag     <= win_pkt.tag;
            cdb_inst_id <= win_pkt.inst_id;
            cdb_wdata   <= win_pkt.wdata;
        end else begin
            cdb_wr      <= 1'b0;
            cdb_tag     <= '0;
            cdb_inst_id <= '0;
            cdb_wdata   <= '0;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < N_SRC; s++) begin
                assert (!(src_req[s] && src_tag[s*TAG_W +: TAG_W] == TAG_W'(CDB_NULL_TAG)))
                    else $error("cdb_arb: request with null tag on source %0d", s);
            end
            assert (!(cdb_wr && cdb_tag == TAG_W'(CDB_NULL_TAG)))
                else $error("cdb_arb: broadcast with null tag");
        end
    end
`endif

endmodule

// File: doc/cdb_arb.md
Name: cdb_arb

Overview:
- Transmitter side of the common data bus (CDB).
- Collects completed results from N_SRC execution units. Each unit presents a result with tag, inst_id and data over a req/rdy handshake.
- Buffers each source in a small FIFO, picks one result per cycle by round-robin, and drives the registered single-write CDB broadcast.
- Reservation stations, ROB and register file consume that broadcast without backpressure.

Parameters:
- N_SRC, 4, number of execution-unit result sources.
- TAG_W, 4, CDB tag width. Tag 0 means "no producer" and is never broadcast.
- ROB_DEPTH, 16, ROB entries.
- ROB_PTR_W, $clog2(ROB_DEPTH), inst_id width.
- DATA_W, 32, result data width.
- Q_DEPTH, 2, per-source FIFO depth. Power of 2, ≥2.
- SRC_W, $clog2(N_SRC), round-robin pointer width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush; discards all buffered and in-flight results.
- src_req  in  N_SRC  per-source result valid.
- src_rdy  out  N_SRC  per-source FIFO not full.
- src_tag  in  N_SRC*TAG_W  per-source result tag; source s occupies bits [s*TAG_W +: TAG_W].
- src_inst_id  in  N_SRC*ROB_PTR_W  per-source ROB index, same packing.
- src_wdata  in  N_SRC*DATA_W  per-source result data, same packing.
- cdb_wr  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_inst_id  out  ROB_PTR_W  broadcast ROB index.
- cdb_wdata  out  DATA_W  broadcast data.

Behaviour:
- Reset (rst=1 at clk edge):
  - All FIFOs empty; rr_ptr=0.
  - cdb_wr=0, cdb_tag=0, cdb_inst_id=0, cdb_wdata=0.
  - Consequently src_rdy is all ones from the first cycle after reset.
  - Reset mid-operation drops every buffered result with no broadcast.
- Enqueue:
  - src_rdy[s] = ~full[s]. It does not depend on src_req or on this cycle's grant, so there is no combinational path from req to rdy.
  - Push when src_req[s] && src_rdy[s].
  - A full FIFO being dequeued this cycle still reports rdy=0.
- Arbitration (combinational on FIFO heads):
  - Candidates are the non-empty FIFOs.
  - Search starts at rr_ptr and wraps modulo N_SRC; the first candidate wins.
- Broadcast registers, on a winner:
  - cdb_wr<=1 and tag/inst_id/wdata <= winner head.
  - Pop the winner.
  - rr_ptr <= (winner+1) mod N_SRC.
- No winner: cdb_wr<=0, cdb_tag/inst_id/wdata <= 0, rr_ptr unchanged.
- Throughput and latency:
  - Exactly one broadcast per cycle maximum.
  - An accepted result appears on the CDB at the earliest 2 cycles after acceptance: pushed at edge T, arbitrated in cycle T+1, cdb_wr high in cycle T+2.
- Simultaneous push and pop on the same FIFO: both occur, count unchanged, order preserved.
- Within a source, FIFO order is strictly preserved. Across sources there is no ordering guarantee.
- Flush (flush=1 at clk edge):
  - All FIFOs emptied; cdb_wr<=0 and outputs zeroed; rr_ptr<=0.
  - Pushes in the flush cycle are discarded.
  - Flush has priority over push and pop.
- Fairness: with all N_SRC sources continuously non-empty, each is granted once every N_SRC cycles.
- Width rules:
  - FIFO pointers are PTR_W+1 bits with the extra wrap bit. Full = MSBs differ and low bits equal; empty = all bits equal.
  - rr_ptr increment wraps explicitly at N_SRC, so N_SRC need not be a power of 2.
- Assertions (sim only):
  - src_req[s] with src_tag slice == 0 is an error.
  - cdb_wr=1 with cdb_tag == 0 is an error.
  - A push into a full FIFO is an error.

Decomposition:
- Shared package cdb_pkg:
  - typedef cdb_pkt_t {tag, inst_id, wdata} sized from TAG_W/ROB_PTR_W/DATA_W.
  - Constant CDB_NULL_TAG = 0.
- Sub-module cdb_src_fifo (one instance per source):
  - Parameterised by Q_DEPTH and packet type.
  - Ports push/pop/flush/full/empty/head.
- Arbiter and output registers stay in cdb_arb.

Test Plan:
- Single source: source 2 pushes tag=5, inst_id=3, wdata=0xDEADBEEF at T -> cdb_wr=1 at T+2 with exactly those fields, 0 elsewhere; rr_ptr=3 after.
- All four sources push in the same cycle, tags 1..4, rr_ptr=0 -> broadcasts tags 1,2,3,4 on 4 consecutive cycles, then cdb_wr=0 and outputs zero.
- Backpressure: source 0 holds req with tags 6,7,8 back-to-back while sources 1..3 saturate -> src_rdy[0]=0 after 2 unconsumed pushes; tag 8 is accepted only once rdy=1; order 6,7,8 preserved; no loss or duplication.
- Wrap-around: rr_ptr=3 with sources 0 and 3 non-empty -> source 3 granted first, then source 0; rr_ptr=1 after.
- Flush: FIFOs hold 5 results and cdb_wr=1 at flush edge -> next cycle cdb_wr=0, all src_rdy=1; a push in the flush cycle never appears on the CDB.
- Reset mid-stream: rst for 1 cycle while 3 results are queued -> no broadcasts afterwards, outputs 0, rr_ptr=0; the next push is broadcast at +2 cycles.
